// File: rtl/act_pkg.sv
// act_pkg: shared types and helpers for the activation pipeline.
//   act_mode_e  : per-sample activation mode (tanh LUT, sigmoid LUT, ReLU, bypass)
//   TBL_*       : table-select encodings for the configuration port
//   sat_signed(): clamp a wide signed value to a signed field of width w
package act_pkg;

   typedef enum logic [1:0] {
      ACT_TANH = 2'd0,
      ACT_SIGM = 2'd1,
      ACT_RELU = 2'd2,
      ACT_BYP  = 2'd3
   } act_mode_e;

   localparam logic TBL_TANH = 1'b0;
   localparam logic TBL_SIGM = 1'b1;

   // Working width for interpolation arithmetic; must exceed 2*DATA_W+1.
   localparam int unsigned SAT_W = 32;

   // Saturate x into the signed range of a w-bit field (result still SAT_W wide).
   function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] x,
                                                          input int unsigned             w);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
      lo = ~hi;
      if (x > hi)      sat_signed = hi;
      else if (x < lo) sat_signed = lo;
      else             sat_signed = x;
   endfunction

endpackage

// File: rtl/act_lut_ram.sv
// act_lut_ram: one-write / NRD-read synchronous lookup table (no reset on contents).
//   clk    : clock
//   we     : write strobe; waddr/wdata written at the rising edge
//   re     : read enable; all read ports register mem[raddr[i]] when high
//   raddr  : NRD packed read addresses
//   rdata  : NRD registered read data (old contents on same-cycle write/read collision)
module act_lut_ram #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned NRD    = 2
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [ADDR_W-1:0]            waddr,
   input  logic [DATA_W-1:0]            wdata,
   input  logic                         re,
   input  logic [NRD-1:0][ADDR_W-1:0]   raddr,
   output logic [NRD-1:0][DATA_W-1:0]   rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Table write port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Registered read ports; held while re is low so stalled stages keep their operands
   always_ff @(posedge clk) begin
      if (re) begin
         for (int i = 0; i < int'(NRD); i++) rdata[i] <= mem[raddr[i]];
      end
   end

endmodule

// File: rtl/act_lut_pipe.sv
// act_lut_pipe: pipelined per-sample activation (tanh LUT, sigmoid LUT, ReLU, bypass)
// with valid/ready streaming and programmable tables.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake (in_ready is combinational)
//   in_data, in_mode     : signed sample and its activation mode
//   out_valid/out_ready  : output handshake
//   out_data, out_mode   : activation result and the mode used
//   cfg_we/sel/addr/data : table write port (sel 0 tanh, 1 sigmoid)
//   occupancy            : samples accepted but not yet delivered
// Build option: LINEAR_INTERP_EN adds linear interpolation between adjacent
// table entries and one extra pipeline stage (latency 3 instead of 2).
module act_lut_pipe
   import act_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_mode,
   input  logic              cfg_we,
   input  logic              cfg_sel,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [DATA_W-1:0] cfg_data,
   output logic [1:0]        occupancy
);

`ifdef LINEAR_INTERP_EN
   localparam int unsigned NRD    = 2;
   localparam int unsigned FRAC_W = DATA_W - ADDR_W;
   localparam int unsigned FW     = (FRAC_W == 0) ? 1 : FRAC_W;
   localparam logic [ADDR_W-1:0] IDX_MAXPOS = ADDR_W'((1 << (ADDR_W - 1)) - 1);
`else
   localparam int unsigned NRD    = 1;
`endif

   logic                           advance_c;
   logic                           accept_c;
   logic                           deliver_c;
   logic [ADDR_W-1:0]              idx_c;
   logic [NRD-1:0][ADDR_W-1:0]     raddr_c;
   logic [NRD-1:0][DATA_W-1:0]     tanh_rd;
   logic [NRD-1:0][DATA_W-1:0]     sigm_rd;

   logic                           s1_valid;
   act_mode_e                      s1_mode;
   logic [DATA_W-1:0]              s1_data;

   // Inputs to the output register stage
   logic                           pre_valid_c;
   act_mode_e                      pre_mode_c;
   logic [DATA_W-1:0]              pre_data_c;
   logic [DATA_W-1:0]              lut_y_c;
   logic [DATA_W-1:0]              res_c;

   // Whole pipe moves together; only a stalled, full output register blocks it
   assign advance_c = out_ready || !out_valid;
   assign in_ready  = advance_c;
   assign accept_c  = in_valid && advance_c;
   assign deliver_c = out_valid && out_ready;

   assign idx_c = in_data[DATA_W-1 -: ADDR_W];

   // Table read addresses: port 0 = entry[index], port 1 = upper neighbour
   always_comb begin
      raddr_c    = '0;
      raddr_c[0] = idx_c;
`ifdef LINEAR_INTERP_EN
      // Largest positive index has no upper neighbour; reuse it instead of wrapping negative
      raddr_c[1] = (idx_c == IDX_MAXPOS) ? idx_c : idx_c + ADDR_W'(1);
`endif
   end

   act_lut_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) u_tanh_ram (
      .clk   (clk),
      .we    (cfg_we && (cfg_sel == TBL_TANH)),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .re    (advance_c),
      .raddr (raddr_c),
      .rdata (tanh_rd)
   );

   act_lut_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) u_sigm_ram (
      .clk   (clk),
      .we    (cfg_we && (cfg_sel == TBL_SIGM)),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .re    (advance_c),
      .raddr (raddr_c),
      .rdata (sigm_rd)
   );

   // S1: sample/mode register alongside the synchronous table read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_mode  <= ACT_TANH;
         s1_data  <= '0;
      end else if (advance_c) begin
         s1_valid <= in_valid;
         s1_mode  <= act_mode_e'(in_mode);
         s1_data  <= in_data;
      end
   end

`ifdef LINEAR_INTERP_EN
   logic [FW-1:0]           frac_c;
   logic [FW-1:0]           s1_frac;
   logic                    s2_valid;
   act_mode_e               s2_mode;
   logic [DATA_W-1:0]       s2_data;
   logic [DATA_W-1:0]       s2_e0;
   logic [DATA_W-1:0]       s2_e1;
   logic [FW-1:0]           s2_frac;
   logic signed [SAT_W-1:0] e0_s;
   logic signed [SAT_W-1:0] e1_s;
   logic signed [SAT_W-1:0] fr_s;
   logic signed [SAT_W-1:0] dl_s;

   // Fraction = sample bits below the index; zero when the index uses every bit
   if (FRAC_W == 0) begin : g_nofrac
      assign frac_c = '0;
   end else begin : g_frac
      assign frac_c = in_data[FW-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s1_frac <= '0;
      else if (advance_c) s1_frac <= frac_c;
   end

   // S2: pick the table for this sample's mode and register both neighbours
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_mode  <= ACT_TANH;
         s2_data  <= '0;
         s2_e0    <= '0;
         s2_e1    <= '0;
         s2_frac  <= '0;
      end else if (advance_c) begin
         s2_valid <= s1_valid;
         s2_mode  <= s1_mode;
         s2_data  <= s1_data;
         s2_e0    <= (s1_mode == ACT_SIGM) ? sigm_rd[0] : tanh_rd[0];
         s2_e1    <= (s1_mode == ACT_SIGM) ? sigm_rd[1] : tanh_rd[1];
         s2_frac  <= s1_frac;
      end
   end

   // y = e0 + ((e1 - e0) * frac >>> F), saturated to DATA_W
   always_comb begin
      e0_s    = SAT_W'(signed'(s2_e0));
      e1_s    = SAT_W'(signed'(s2_e1));
      fr_s    = signed'(SAT_W'(s2_frac));
      dl_s    = ((e1_s - e0_s) * fr_s) >>> FRAC_W;
      lut_y_c = DATA_W'(sat_signed(e0_s + dl_s, DATA_W));
   end

   assign pre_valid_c = s2_valid;
   assign pre_mode_c  = s2_mode;
   assign pre_data_c  = s2_data;
`else
   assign lut_y_c     = (s1_mode == ACT_SIGM) ? sigm_rd[0] : tanh_rd[0];
   assign pre_valid_c = s1_valid;
   assign pre_mode_c  = s1_mode;
   assign pre_data_c  = s1_data;
`endif

   // Result select by mode
   always_comb begin
      res_c = pre_data_c;
      case (pre_mode_c)
         ACT_TANH, ACT_SIGM: res_c = lut_y_c;
         ACT_RELU:           res_c = pre_data_c[DATA_W-1] ? '0 : pre_data_c;
         default:            res_c = pre_data_c;
      endcase
   end

   // Output register; holds while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_mode  <= 2'd0;
      end else if (advance_c) begin
         out_valid <= pre_valid_c;
         out_data  <= res_c;
         out_mode  <= 2'(pre_mode_c);
      end
   end

   // Samples in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occupancy <= 2'd0;
      end else if (accept_c && !deliver_c) begin
         occupancy <= occupancy + 2'd1;
      end else if (deliver_c && !accept_c) begin
         occupancy <= occupancy - 2'd1;
      end
   end

endmodule

// File: tb/tb_act_lut_pipe.sv
// Testbench for act_lut_pipe (default parameters DATA_W=8, ADDR_W=8).
// A queue-based reference model predicts every delivered sample from the
// table contents at acceptance time; directed tests pin it with literal values.
// With LINEAR_INTERP_EN defined a second instance (ADDR_W=4) exercises interpolation.
module tb_act_lut_pipe;

`ifdef LINEAR_INTERP_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic [1:0] in_mode = 2'd0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_data;
   logic [1:0] out_mode;
   logic       cfg_we = 1'b0;
   logic       cfg_sel = 1'b0;
   logic [7:0] cfg_addr = 8'h00;
   logic [7:0] cfg_data = 8'h00;
   logic [1:0] occupancy;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   act_lut_pipe #(.DATA_W(8), .ADDR_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] tanh_m [256];
   logic [7:0] sigm_m [256];

   typedef struct {
      logic [7:0] d;
      logic [1:0] m;
      int         acc;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] got_d[$];
   logic [1:0] got_m[$];
   int         got_lat[$];
   logic       hold = 1'b0;
   logic [7:0] hold_d;
   logic [1:0] hold_m;

   // With ADDR_W == DATA_W there are no fraction bits, so LUT modes return entry[sample]
   function automatic logic [7:0] model(input logic [7:0] d, input logic [1:0] m);
      case (m)
         2'd0:    return tanh_m[d];
         2'd1:    return sigm_m[d];
         2'd2:    return (d >= 8'h80) ? 8'h00 : d;
         default: return d;
      endcase
   endfunction

   // tanh of the sample read as Q4.4, scaled by 128, rounded, saturated to int8
   function automatic logic [7:0] tanh_q(input int i);
      int  s;
      int  v;
      real r;
      s = (i >= 128) ? i - 256 : i;
      r = $tanh(s / 16.0) * 128.0;
      v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
      if (v > 127)  v = 127;
      if (v < -128) v = -128;
      return 8'(v);
   endfunction

   // Compare process: sampled on the falling edge, away from the active edge
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         exp_q.delete();
         hold = 1'b0;
      end else begin
         chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
         if (hold) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(hold_d));
            chk("stall_mode", 32'(out_mode), 32'(hold_m));
         end
         hold   = out_valid && !out_ready;
         hold_d = out_data;
         hold_m = out_mode;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_output: got %02h with nothing outstanding", out_data);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", 32'(out_data), 32'(e.d));
               chk("out_mode", 32'(out_mode), 32'(e.m));
               got_d.push_back(out_data);
               got_m.push_back(out_mode);
               got_lat.push_back(cyc - e.acc);
            end
         end
         if (in_valid && in_ready) begin
            e.d   = model(in_data, in_mode);
            e.m   = in_mode;
            e.acc = cyc;
            exp_q.push_back(e);
         end
         // Model write lands after the same-cycle read: old value is returned
         if (cfg_we) begin
            if (cfg_sel) sigm_m[cfg_addr] = cfg_data;
            else         tanh_m[cfg_addr] = cfg_data;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [7:0] d, input logic [1:0] m);
      logic ok;
      int   n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      do begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 50);
      if (!ok) chk("send_timeout", 32'(ok), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic cfg_write(input logic sel, input logic [7:0] a, input logic [7:0] d);
      cfg_we   = 1'b1;
      cfg_sel  = sel;
      cfg_addr = a;
      cfg_data = d;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({nm, "_drain"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic clear_log();
      got_d.delete();
      got_m.delete();
      got_lat.delete();
   endtask

`ifdef LINEAR_INTERP_EN
   logic       i_in_valid = 1'b0;
   logic       i_in_ready;
   logic [7:0] i_in_data = 8'h00;
   logic       i_out_valid;
   logic [7:0] i_out_data;
   logic [1:0] i_out_mode;
   logic       i_cfg_we = 1'b0;
   logic [3:0] i_cfg_addr = 4'h0;
   logic [7:0] i_cfg_data = 8'h00;
   logic [1:0] i_occupancy;

   act_lut_pipe #(.DATA_W(8), .ADDR_W(4)) dut_i (
      .clk(clk), .rst_n(rst_n),
      .in_valid(i_in_valid), .in_ready(i_in_ready), .in_data(i_in_data), .in_mode(2'd0),
      .out_valid(i_out_valid), .out_ready(1'b1), .out_data(i_out_data), .out_mode(i_out_mode),
      .cfg_we(i_cfg_we), .cfg_sel(1'b0), .cfg_addr(i_cfg_addr), .cfg_data(i_cfg_data),
      .occupancy(i_occupancy)
   );
`endif

   // Watchdog
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- directed tests ----------------
   initial begin
      logic [7:0] tanh_in  [6];
      logic [7:0] tanh_out [6];
      logic [7:0] sd [3];
      logic       acc;
      int         k;
      int         n;

      tanh_in  = '{8'h00, 8'h01, 8'h10, 8'h7F, 8'h80, 8'hFF};
      tanh_out = '{8'h00, 8'h08, 8'h61, 8'h7F, 8'h80, 8'hF8};
      sd       = '{8'h11, 8'h22, 8'h33};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'h00);
      chk("rst_out_mode", 32'(out_mode), 32'd0);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Load full tanh table back to back, preload one sigmoid entry
      for (int i = 0; i < 256; i++) begin
         cfg_we   = 1'b1;
         cfg_sel  = 1'b0;
         cfg_addr = 8'(i);
         cfg_data = tanh_q(i);
         @(posedge clk);
         #1;
      end
      cfg_we = 1'b0;
      cfg_write(1'b1, 8'h10, 8'h33);

      // Tanh stream, back to back
      clear_log();
      for (int i = 0; i < 6; i++) send(tanh_in[i], 2'd0);
      drain("tanh");
      chk("tanh_count", 32'(got_d.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("tanh_lit%0d", i), 32'(got_d[i]), 32'(tanh_out[i]));
         chk($sformatf("tanh_lat%0d", i), 32'(got_lat[i]), 32'(LAT));
      end

      // ReLU and bypass
      clear_log();
      send(8'h45, 2'd2);
      send(8'hC0, 2'd2);
      send(8'h00, 2'd2);
      send(8'hA5, 2'd3);
      drain("relu");
      chk("relu_count", 32'(got_d.size()), 32'd4);
      chk("relu_pos", 32'(got_d[0]), 32'h45);
      chk("relu_neg", 32'(got_d[1]), 32'h00);
      chk("relu_zero", 32'(got_d[2]), 32'h00);
      chk("byp_data", 32'(got_d[3]), 32'hA5);
      chk("relu_mode", 32'(got_m[0]), 32'd2);
      chk("byp_mode", 32'(got_m[3]), 32'd3);

      // Backpressure: consumer stalled for 5 cycles with 3 samples offered
      clear_log();
      out_ready = 1'b0;
      k         = 0;
      in_valid  = 1'b1;
      in_mode   = 2'd3;
      in_data   = sd[0];
      repeat (5) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            k++;
            if (k < 3) in_data = sd[k];
            else       in_valid = 1'b0;
         end
      end
      chk("stall_accepts", 32'(k), 32'(LAT));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_occupancy", 32'(occupancy), 32'(LAT));
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_head", 32'(out_data), 32'h11);
      out_ready = 1'b1;
      n = 0;
      while (k < 3 && n < 20) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         n++;
         if (acc) begin
            k++;
            if (k < 3) in_data = sd[k];
            else       in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      drain("stall");
      chk("stall_count", 32'(got_d.size()), 32'd3);
      for (int i = 0; i < 3; i++) chk($sformatf("stall_order%0d", i), 32'(got_d[i]), 32'(sd[i]));

      // Sigmoid write colliding with a read of the same entry
      clear_log();
      cfg_we   = 1'b1;
      cfg_sel  = 1'b1;
      cfg_addr = 8'h10;
      cfg_data = 8'h55;
      send(8'h10, 2'd1);
      cfg_we = 1'b0;
      send(8'h10, 2'd1);
      drain("sigm");
      chk("sigm_count", 32'(got_d.size()), 32'd2);
      chk("sigm_old", 32'(got_d[0]), 32'h33);
      chk("sigm_new", 32'(got_d[1]), 32'h55);

      // Reset with two samples in flight
      clear_log();
      out_ready = 1'b0;
      send(8'h5A, 2'd3);
      send(8'h6B, 2'd3);
      chk("pre_rst_occupancy", 32'(occupancy), 32'd2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_occupancy", 32'(occupancy), 32'd0);
      chk("mid_rst_out_data", 32'(out_data), 32'h00);
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("post_rst_no_output", 32'(got_d.size()), 32'd0);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);

`ifdef LINEAR_INTERP_EN
      // Interpolation: entries[2]=0x20,[3]=0x40,[7]=0x50,[8]=0x90 on a 16-entry table
      i_cfg_we = 1'b1;
      i_cfg_addr = 4'h2; i_cfg_data = 8'h20; @(posedge clk); #1;
      i_cfg_addr = 4'h3; i_cfg_data = 8'h40; @(posedge clk); #1;
      i_cfg_addr = 4'h7; i_cfg_data = 8'h50; @(posedge clk); #1;
      i_cfg_addr = 4'h8; i_cfg_data = 8'h90; @(posedge clk); #1;
      i_cfg_we = 1'b0;
      i_in_valid = 1'b1;
      i_in_data  = 8'h28;
      @(posedge clk); #1;
      i_in_data  = 8'h7F;
      @(posedge clk); #1;
      i_in_valid = 1'b0;
      @(posedge clk); #1;
      chk("interp_valid0", 32'(i_out_valid), 32'd1);
      chk("interp_mid", 32'(i_out_data), 32'h30);
      @(posedge clk); #1;
      chk("interp_valid1", 32'(i_out_valid), 32'd1);
      chk("interp_top_nowrap", 32'(i_out_data), 32'h50);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
